// File: rtl/sync_fifo_param_if.sv
// Handshake/data bundle for sync_fifo_param: master drives writes/reads/clear, slave returns data, flags and count.
interface sync_fifo_param_if #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) ();
  logic             winc;
  logic [DSIZE-1:0] wdata;
  logic             rinc;
  logic             clr_err;
  logic [DSIZE-1:0] rdata;
  logic             wfull;
  logic             rempty;
  logic             walmost_full;
  logic             ralmost_empty;
  logic [ASIZE:0]   fill_count;
  logic             overflow;
  logic             underflow;

  modport master (
    output winc, wdata, rinc, clr_err,
    input  rdata, wfull, rempty, walmost_full, ralmost_empty, fill_count, overflow, underflow
  );

  modport slave (
    input  winc, wdata, rinc, clr_err,
    output rdata, wfull, rempty, walmost_full, ralmost_empty, fill_count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered flags/count; reads return data one cycle after rinc (or fall-through with SYNC_FIFO_FWFT_EN).
// Backpressure: writes dropped while wfull, reads ignored while rempty; both latch sticky error flags until clr_err.
module sync_fifo_param #(
  parameter int DSIZE    = 8,
  parameter int ASIZE    = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input logic               clk,
  input logic               rst_n,
  sync_fifo_param_if.slave  fifo_if
);

  localparam int DEPTH = 1 << ASIZE;

  typedef logic [ASIZE:0] ptr_t;

  logic [DSIZE-1:0] r_mem [DEPTH];
  ptr_t             r_wptr;
  ptr_t             r_rptr;
  ptr_t             r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_afull;
  logic             r_aempty;
  logic             r_ovf;
  logic             r_udf;

  logic             w_wr;
  logic             w_rd;
  ptr_t             w_wptr_nxt;
  ptr_t             w_rptr_nxt;
  ptr_t             w_cnt_nxt;
  logic             w_full_nxt;
  logic             w_empty_nxt;

  always_comb begin
    w_wr       = fifo_if.winc && !r_full;
    w_rd       = fifo_if.rinc && !r_empty;
    w_wptr_nxt = r_wptr + ptr_t'(w_wr);
    w_rptr_nxt = r_rptr + ptr_t'(w_rd);
    w_cnt_nxt  = r_count;
    if (w_wr && !w_rd) begin
      w_cnt_nxt = r_count + ptr_t'(1);
    end else if (!w_wr && w_rd) begin
      w_cnt_nxt = r_count - ptr_t'(1);
    end
    // Same address, opposite wrap bit means the writer lapped the reader.
    w_full_nxt  = (w_wptr_nxt[ASIZE-1:0] == w_rptr_nxt[ASIZE-1:0]) &&
                  (w_wptr_nxt[ASIZE] != w_rptr_nxt[ASIZE]);
    w_empty_nxt = (w_wptr_nxt == w_rptr_nxt);
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr[ASIZE-1:0]] <= fifo_if.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_wptr   <= w_wptr_nxt;
      r_rptr   <= w_rptr_nxt;
      r_count  <= w_cnt_nxt;
      r_full   <= w_full_nxt;
      r_empty  <= w_empty_nxt;
      r_afull  <= (w_cnt_nxt >= ptr_t'(AF_LEVEL));
      r_aempty <= (w_cnt_nxt <= ptr_t'(AE_LEVEL));
      // A new error event outranks a clear in the same cycle.
      r_ovf    <= (fifo_if.winc && r_full)  || (r_ovf && !fifo_if.clr_err);
      r_udf    <= (fifo_if.rinc && r_empty) || (r_udf && !fifo_if.clr_err);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is shown directly; forced to zero while empty so stale memory never leaks out.
  assign fifo_if.rdata = r_empty ? '0 : r_mem[r_rptr[ASIZE-1:0]];
`else
  logic [DSIZE-1:0] r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (w_rd) begin
      r_rdata <= r_mem[r_rptr[ASIZE-1:0]];
    end
  end

  assign fifo_if.rdata = r_rdata;
`endif

  assign fifo_if.wfull         = r_full;
  assign fifo_if.rempty        = r_empty;
  assign fifo_if.walmost_full  = r_afull;
  assign fifo_if.ralmost_empty = r_aempty;
  assign fifo_if.fill_count    = r_count;
  assign fifo_if.overflow      = r_ovf;
  assign fifo_if.underflow     = r_udf;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: table-driven fill/drain plus hand-written corner sequences, checked against a queue model.
module tb_sync_fifo_param;

  localparam int DEP = 16;
  localparam int AF  = 14;
  localparam int AE  = 2;

  logic clk;
  logic rst_n;

  sync_fifo_param_if #(.DSIZE(8), .ASIZE(4)) bus ();

  sync_fifo_param #(.DSIZE(8), .ASIZE(4), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .fifo_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       w;
    logic [7:0] d;
    logic       r;
    logic       c;
    logic [4:0] cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ovf;
  } vec_t;

  vec_t       vt[34];
  logic [7:0] q[$];
  logic [7:0] m_rdata;
  logic       m_ovf;
  logic       m_udf;
  int         total;
  int         bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_state();
    int n;
    logic [7:0] exp_rd;
    n = q.size();
`ifdef SYNC_FIFO_FWFT_EN
    exp_rd = (n != 0) ? q[0] : 8'h00;
`else
    exp_rd = m_rdata;
`endif
    chk("fill_count", 32'(bus.fill_count), n);
    chk("rempty", 32'(bus.rempty), 32'(n == 0));
    chk("wfull", 32'(bus.wfull), 32'(n == DEP));
    chk("walmost_full", 32'(bus.walmost_full), 32'(n >= AF));
    chk("ralmost_empty", 32'(bus.ralmost_empty), 32'(n <= AE));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("underflow", 32'(bus.underflow), 32'(m_udf));
    chk("rdata", 32'(bus.rdata), 32'(exp_rd));
  endtask

  // One clock: drive, advance the reference queue, then compare everything.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
    logic full_b, empty_b;
    bus.winc    = w;
    bus.wdata   = d;
    bus.rinc    = r;
    bus.clr_err = c;
    full_b  = (q.size() == DEP);
    empty_b = (q.size() == 0);
    @(posedge clk);
    #1;
    m_ovf = (w && full_b) || (m_ovf && !c);
    m_udf = (r && empty_b) || (m_udf && !c);
    if (r && !empty_b) m_rdata = q.pop_front();
    if (w && !full_b) q.push_back(d);
    check_state();
  endtask

  initial begin
    total = 0;
    bad = 0;
    m_rdata = 8'h00;
    m_ovf = 1'b0;
    m_udf = 1'b0;

    for (int i = 0; i < 16; i++) begin
      vt[i] = '{w: 1'b1, d: 8'(i + 1), r: 1'b0, c: 1'b0, cnt: 5'(i + 1),
                full: (i + 1 == DEP), empty: 1'b0, af: (i + 1 >= AF), ae: (i + 1 <= AE), ovf: 1'b0};
    end
    vt[16] = '{w: 1'b1, d: 8'hAA, r: 1'b0, c: 1'b0, cnt: 5'd16,
               full: 1'b1, empty: 1'b0, af: 1'b1, ae: 1'b0, ovf: 1'b1};
    vt[17] = '{w: 1'b0, d: 8'h00, r: 1'b0, c: 1'b1, cnt: 5'd16,
               full: 1'b1, empty: 1'b0, af: 1'b1, ae: 1'b0, ovf: 1'b0};
    for (int k = 1; k <= 16; k++) begin
      vt[17 + k] = '{w: 1'b0, d: 8'h00, r: 1'b1, c: 1'b0, cnt: 5'(16 - k),
                     full: 1'b0, empty: (k == 16), af: (16 - k >= AF), ae: (16 - k <= AE), ovf: 1'b0};
    end

    rst_n = 1'b0;
    bus.winc = 1'b0;
    bus.wdata = 8'h00;
    bus.rinc = 1'b0;
    bus.clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rempty", 32'(bus.rempty), 1);
    chk("rst_wfull", 32'(bus.wfull), 0);
    chk("rst_ralmost_empty", 32'(bus.ralmost_empty), 1);
    chk("rst_fill_count", 32'(bus.fill_count), 0);
    chk("rst_rdata", 32'(bus.rdata), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill to full, overflow attempt, clear, drain; read data comes from the queue model.
    for (int i = 0; i < 34; i++) begin
      cyc(vt[i].w, vt[i].d, vt[i].r, vt[i].c);
      chk("tbl_count", 32'(bus.fill_count), 32'(vt[i].cnt));
      chk("tbl_wfull", 32'(bus.wfull), 32'(vt[i].full));
      chk("tbl_rempty", 32'(bus.rempty), 32'(vt[i].empty));
      chk("tbl_walmost_full", 32'(bus.walmost_full), 32'(vt[i].af));
      chk("tbl_ralmost_empty", 32'(bus.ralmost_empty), 32'(vt[i].ae));
      chk("tbl_overflow", 32'(bus.overflow), 32'(vt[i].ovf));
    end

    // Underflow on empty, then simultaneous write/read while empty.
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("udf_set", 32'(bus.underflow), 1);
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    chk("udf_wr_count", 32'(bus.fill_count), 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("udf_clear", 32'(bus.underflow), 0);

    // Steady-state streaming at occupancy 8 across pointer wrap.
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
      chk("stream_count", 32'(bus.fill_count), 8);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre_rst_count", 32'(bus.fill_count), 5);

    // Asynchronous reset in the middle of a burst.
    cyc(1'b1, 8'hC0, 1'b1, 1'b0);
    cyc(1'b1, 8'hC1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    bus.winc = 1'b0;
    bus.rinc = 1'b0;
    #1;
    q.delete();
    m_rdata = 8'h00;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    chk("mid_rst_rempty", 32'(bus.rempty), 1);
    chk("mid_rst_count", 32'(bus.fill_count), 0);
    chk("mid_rst_walmost_full", 32'(bus.walmost_full), 0);
    chk("mid_rst_ralmost_empty", 32'(bus.ralmost_empty), 1);
    chk("mid_rst_rdata", 32'(bus.rdata), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_udf", 32'(bus.underflow), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
